// File: rtl/tmds_video_timing_gen.sv
// Video timing and test-pattern source feeding the three TMDS channel encoders.
// Every output is a registered decode of the current (hcnt, vcnt), so it lags the
// counters by one PIXCLK cycle.
module tmds_video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter logic [23:0] SOLID_RGB = 24'hFF0000
) (
    input  logic       PIXCLK,
    input  logic       RST_N,
    input  logic [1:0] PATTERN,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VDE,
    output logic [1:0] CTRL_B,
    output logic [7:0] RED,
    output logic [7:0] GREEN,
    output logic [7:0] BLUE,
    output logic       FRAME_START
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_FIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic [11:0] bar_px_q, bar_px_d;
    // Index 8 means "past the last full bar" and renders black.
    logic [3:0]  bar_idx_q, bar_idx_d;
    logic [1:0]  pattern_q, pattern_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        vde_q, vde_d;
    logic        fs_q, fs_d;
    logic [23:0] rgb_q, rgb_d;

    logic        at_origin;
    logic        active;
    logic [1:0]  pat_sel;

    // Next-state for the raster counters and the colour-bar sub-counter.
    always_comb begin
        hcnt_d    = hcnt_q + 12'd1;
        vcnt_d    = vcnt_q;
        bar_px_d  = bar_px_q + 12'd1;
        bar_idx_d = bar_idx_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d    = '0;
            vcnt_d    = (vcnt_q == V_LAST) ? '0 : vcnt_q + 12'd1;
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_LAST) begin
            bar_px_d = '0;
            if (bar_idx_q != 4'd8) begin
                bar_idx_d = bar_idx_q + 4'd1;
            end
        end
    end

    // Region decode and pattern generation for the current counter position.
    always_comb begin
        at_origin = (hcnt_q == '0) && (vcnt_q == '0);
        // The first pixel of a frame already uses the freshly sampled pattern.
        pat_sel   = at_origin ? PATTERN : pattern_q;
        pattern_d = pat_sel;
        active    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        hsync_d   = ((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST)) ? HS_POL : ~HS_POL;
        vsync_d   = ((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST)) ? VS_POL : ~VS_POL;
        vde_d     = active;
        fs_d      = at_origin;
        rgb_d     = '0;
        if (active) begin
            unique case (pat_sel)
                2'd0: begin
                    case (bar_idx_q)
                        4'd0:    rgb_d = 24'hFFFFFF;
                        4'd1:    rgb_d = 24'hFFFF00;
                        4'd2:    rgb_d = 24'h00FFFF;
                        4'd3:    rgb_d = 24'h00FF00;
                        4'd4:    rgb_d = 24'hFF00FF;
                        4'd5:    rgb_d = 24'hFF0000;
                        4'd6:    rgb_d = 24'h0000FF;
                        default: rgb_d = 24'h000000;
                    endcase
                end
                2'd1: rgb_d = {3{hcnt_q[7:0]}};
                2'd2: rgb_d = (hcnt_q[4] ^ vcnt_q[4]) ? 24'hFFFFFF : 24'h000000;
                2'd3: rgb_d = SOLID_RGB;
            endcase
        end
    end

    // State and output registers with synchronous reset to the inactive levels.
    always_ff @(posedge PIXCLK) begin
        if (!RST_N) begin
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            pattern_q <= '0;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            vde_q     <= 1'b0;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            pattern_q <= pattern_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            vde_q     <= vde_d;
            fs_q      <= fs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign CTRL_B      = {vsync_q, hsync_q};
    assign VDE         = vde_q;
    assign FRAME_START = fs_q;
    assign RED         = rgb_q[23:16];
    assign GREEN       = rgb_q[15:8];
    assign BLUE        = rgb_q[7:0];

endmodule

// File: tb/tb_tmds_video_timing_gen.sv
// Self-checking bench for tmds_video_timing_gen. Horizontal timing is the default
// 800-pixel line; the frame is shortened to 24 lines to keep run time small.
module tb_tmds_video_timing_gen;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 18;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam logic        HS_POL   = 1'b0;
    localparam logic        VS_POL   = 1'b0;
    localparam logic [23:0] SOLID    = 24'hFF0000;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int BAR_W    = H_ACTIVE / 8;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    logic       PIXCLK = 1'b0;
    logic       RST_N;
    logic [1:0] PATTERN;
    logic       HSYNC, VSYNC, VDE, FRAME_START;
    logic [1:0] CTRL_B;
    logic [7:0] RED, GREEN, BLUE;

    tmds_video_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .SOLID_RGB(SOLID)
    ) dut (
        .PIXCLK     (PIXCLK),
        .RST_N      (RST_N),
        .PATTERN    (PATTERN),
        .HSYNC      (HSYNC),
        .VSYNC      (VSYNC),
        .VDE        (VDE),
        .CTRL_B     (CTRL_B),
        .RED        (RED),
        .GREEN      (GREEN),
        .BLUE       (BLUE),
        .FRAME_START(FRAME_START)
    );

    always #5 PIXCLK = ~PIXCLK;

    int checks = 0;
    int errors = 0;

    // Reference model: raster position, latched pattern, expected output vector.
    int          m_h, m_v;
    logic [1:0]  m_pat;
    int          disp_h, disp_v;
    logic [29:0] exp_vec;
    logic [29:0] dut_vec;
    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    assign dut_vec = {HSYNC, VSYNC, CTRL_B, VDE, FRAME_START, RED, GREEN, BLUE};

    function automatic logic [23:0] ref_pixel(input logic [1:0] pat, input int h, input int v);
        logic [7:0] g;
        case (pat)
            2'd0: return (h / BAR_W < 8) ? bar_rgb[h / BAR_W] : 24'h0;
            2'd1: begin
                g = 8'(h % 256);
                return {g, g, g};
            end
            2'd2: return (((h / 16) % 2) != ((v / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
            default: return SOLID;
        endcase
    endfunction

    // Predict what the coming edge will present, advance the model, then clock.
    task automatic tick();
        logic hs, vs, de, fs;
        logic [23:0] rgb;
        if (!RST_N) begin
            exp_vec = {~HS_POL, ~VS_POL, ~VS_POL, ~HS_POL, 1'b0, 1'b0, 24'h0};
            disp_h = -1;
            disp_v = -1;
            m_h = 0;
            m_v = 0;
            m_pat = 2'd0;
        end else begin
            if (m_h == 0 && m_v == 0) m_pat = PATTERN;
            de  = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
            hs  = (m_h >= HS_FIRST && m_h <= HS_LAST) ? HS_POL : ~HS_POL;
            vs  = (m_v >= VS_FIRST && m_v <= VS_LAST) ? VS_POL : ~VS_POL;
            fs  = (m_h == 0 && m_v == 0);
            rgb = de ? ref_pixel(m_pat, m_h, m_v) : 24'h0;
            exp_vec = {hs, vs, vs, hs, de, fs, rgb};
            disp_h = m_h;
            disp_v = m_v;
            m_h = (m_h + 1) % H_TOTAL;
            if (m_h == 0) m_v = (m_v + 1) % V_TOTAL;
        end
        @(posedge PIXCLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            PATTERN = 2'($urandom);
            tick();
            checks++;
            if ({HSYNC, VSYNC, CTRL_B, VDE, FRAME_START, RED, GREEN, BLUE} !== 30'h3C000000) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want %h", i, dut_vec, 30'h3C000000);
            end
        end
    endtask

    task automatic test_line_timing();
        PATTERN = 2'd0;
        RST_N = 1'b1;
        for (int c = 0; c < 3 * H_TOTAL; c++) begin
            int x;
            logic want_hs;
            x = c % H_TOTAL;
            tick();
            want_hs = (x >= 656 && x <= 751) ? 1'b0 : 1'b1;
            checks++;
            if (HSYNC !== want_hs) begin
                errors++;
                $display("FAIL line hsync cyc %0d: got %b want %b", c, HSYNC, want_hs);
            end
            checks++;
            if (VDE !== (x < 640)) begin
                errors++;
                $display("FAIL line vde cyc %0d: got %b want %b", c, VDE, x < 640);
            end
            checks++;
            if (FRAME_START !== (c == 0)) begin
                errors++;
                $display("FAIL line frame_start cyc %0d: got %b want %b", c, FRAME_START, c == 0);
            end
            if (c == 0) begin
                checks++;
                if ({RED, GREEN, BLUE} !== 24'hFFFFFF) begin
                    errors++;
                    $display("FAIL first pixel rgb: got %h want FFFFFF", {RED, GREEN, BLUE});
                end
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model pix(%0d,%0d): got %h want %h", disp_h, disp_v, dut_vec,
                         exp_vec);
            end
        end
    endtask

    // Continues the frame from line 3; switches PATTERN to solid on line 10.
    task automatic test_frame_timing();
        for (int c = 3 * H_TOTAL; c < FRAME; c++) begin
            int x, ln;
            logic want_vs, want_de;
            x  = c % H_TOTAL;
            ln = c / H_TOTAL;
            if (c == 10 * H_TOTAL) PATTERN = 2'd3;
            tick();
            want_vs = (c >= VS_FIRST * H_TOTAL && c < (VS_LAST + 1) * H_TOTAL) ? 1'b0 : 1'b1;
            want_de = (ln < V_ACTIVE) && (x < H_ACTIVE);
            checks++;
            if (VSYNC !== want_vs || CTRL_B[1] !== want_vs) begin
                errors++;
                $display("FAIL frame vsync cyc %0d: got %b/%b want %b", c, VSYNC, CTRL_B[1],
                         want_vs);
            end
            checks++;
            if (VDE !== want_de) begin
                errors++;
                $display("FAIL frame vde cyc %0d: got %b want %b", c, VDE, want_de);
            end
            checks++;
            if (HSYNC !== ((x >= HS_FIRST && x <= HS_LAST) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL frame hsync cyc %0d: got %b", c, HSYNC);
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model pix(%0d,%0d): got %h want %h", disp_h, disp_v, dut_vec,
                         exp_vec);
            end
        end
    endtask

    task automatic test_pattern_switch();
        for (int c = 0; c < H_TOTAL; c++) begin
            logic [23:0] want;
            tick();
            want = (c < H_ACTIVE) ? SOLID : 24'h0;
            checks++;
            if (FRAME_START !== (c == 0)) begin
                errors++;
                $display("FAIL switch frame_start cyc %0d: got %b want %b", c, FRAME_START,
                         c == 0);
            end
            checks++;
            if ({RED, GREEN, BLUE} !== want) begin
                errors++;
                $display("FAIL switch rgb cyc %0d: got %h want %h", c, {RED, GREEN, BLUE}, want);
            end
        end
    endtask

    task automatic test_patterns();
        int          px[5]   = '{79, 80, 159, 160, 639};
        logic [23:0] want[5] = '{24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FFFF, 24'h000000};
        // Colour bars on line 0.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        PATTERN = 2'd0;
        for (int c = 0; c < H_ACTIVE; c++) begin
            tick();
            for (int k = 0; k < 5; k++) begin
                if (c == px[k]) begin
                    checks++;
                    if ({RED, GREEN, BLUE} !== want[k]) begin
                        errors++;
                        $display("FAIL bars px %0d: got %h want %h", c, {RED, GREEN, BLUE},
                                 want[k]);
                    end
                end
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model pix(%0d,%0d): got %h want %h", disp_h, disp_v, dut_vec,
                         exp_vec);
            end
        end
        // Grey ramp.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        PATTERN = 2'd1;
        for (int c = 0; c <= 300; c++) begin
            tick();
            if (c == 300) begin
                checks++;
                if ({RED, GREEN, BLUE} !== 24'h2C2C2C) begin
                    errors++;
                    $display("FAIL ramp px 300: got %h want 2C2C2C", {RED, GREEN, BLUE});
                end
            end
        end
        // Checkerboard; PATTERN is scrambled mid-frame and must be ignored.
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        PATTERN = 2'd2;
        for (int c = 0; c <= 16 * H_TOTAL + 16; c++) begin
            tick();
            if (c > 0 && c % 64 == 0) PATTERN = 2'($urandom);
            if (c == 16 || c == 16 * H_TOTAL + 16) begin
                checks++;
                if ({RED, GREEN, BLUE} !== ((c == 16) ? 24'hFFFFFF : 24'h000000)) begin
                    errors++;
                    $display("FAIL checker cyc %0d: got %h", c, {RED, GREEN, BLUE});
                end
            end
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model pix(%0d,%0d): got %h want %h", disp_h, disp_v, dut_vec,
                         exp_vec);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [1:0] p;
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        PATTERN = 2'($urandom);
        for (int c = 0; c < 15 * H_TOTAL + 300; c++) begin
            tick();
            if ($urandom_range(0, 999) == 0) PATTERN = 2'($urandom);
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL model pix(%0d,%0d): got %h want %h", disp_h, disp_v, dut_vec,
                         exp_vec);
            end
        end
        RST_N = 1'b0;
        tick();
        checks++;
        if ({HSYNC, VSYNC, VDE, FRAME_START} !== 4'b1100 || {RED, GREEN, BLUE} !== 24'h0) begin
            errors++;
            $display("FAIL midframe reset: got hs=%b vs=%b de=%b fs=%b rgb=%h want 1 1 0 0 0",
                     HSYNC, VSYNC, VDE, FRAME_START, {RED, GREEN, BLUE});
        end
        p = 2'($urandom);
        RST_N = 1'b1;
        PATTERN = p;
        tick();
        checks++;
        if (FRAME_START !== 1'b1 || VDE !== 1'b1 || {RED, GREEN, BLUE} !== ref_pixel(p, 0, 0))
        begin
            errors++;
            $display("FAIL release after midframe reset: got fs=%b de=%b rgb=%h want 1 1 %h",
                     FRAME_START, VDE, {RED, GREEN, BLUE}, ref_pixel(p, 0, 0));
        end
    endtask

    task automatic test_random();
        int rst_left = 0;
        for (int c = 0; c < 24000; c++) begin
            if (rst_left > 0) begin
                rst_left--;
                RST_N = (rst_left == 0);
            end else if ($urandom_range(0, 3999) == 0) begin
                rst_left = $urandom_range(1, 3);
                RST_N = 1'b0;
            end
            if ($urandom_range(0, 499) == 0) PATTERN = 2'($urandom);
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL random pix(%0d,%0d): got %h want %h", disp_h, disp_v, dut_vec,
                         exp_vec);
            end
        end
        RST_N = 1'b1;
    endtask

    initial begin
        RST_N = 1'b0;
        PATTERN = 2'd0;
        m_h = 0;
        m_v = 0;
        m_pat = 2'd0;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_pattern_switch();
        test_patterns();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_video_timing_gen.md
Name: tmds_video_timing_gen

Overview:
- Video timing and test-pattern source that sits directly upstream of the three per-channel TMDS encoders.
- Generates HSYNC, VSYNC and VDE plus 8-bit R/G/B pixel data, all registered on PIXCLK.
- The blue-channel encoder takes {VSYNC,HSYNC} as its CTRL input; the red and green encoders take CTRL=2'b00.
- Used for bring-up and link test without a framebuffer.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HSYNC active level (0 = active-low)
- VS_POL, 0, VSYNC active level
- SOLID_RGB, 24'hFF0000, colour for pattern 3, {R,G,B}

Ports:
- PIXCLK  in  1  pixel clock; all logic on its rising edge
- RST_N  in  1  synchronous active-low reset
- PATTERN  in  2  pattern select
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- VDE  out  1  video data enable
- CTRL_B  out  2  {VSYNC,HSYNC}, for blue encoder CTRL
- RED  out  8  red pixel
- GREEN  out  8  green pixel
- BLUE  out  8  blue pixel
- FRAME_START  out  1  one-cycle pulse, coincident with first active pixel of each frame

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Counters: hcnt runs 0..H_TOTAL-1 and wraps to 0. vcnt increments when hcnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
- Region decode:
  - Active when hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - HSYNC asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], on every line including vertical blanking.
  - VSYNC asserted for whole lines vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], switching on hcnt=0 boundaries.
- Output registers: all outputs are registered decodes of the current (hcnt,vcnt), so there is 1 cycle of latency. At every edge the outputs take the decode of the pre-edge counter value and the counters advance.
- Reset (RST_N low at an edge), including mid-frame:
  - hcnt=0, vcnt=0, latched pattern=0.
  - HSYNC=~HS_POL, VSYNC=~VS_POL, CTRL_B reflects these inactive levels.
  - VDE=0, RED/GREEN/BLUE=0, FRAME_START=0.
- First edge with RST_N high: outputs show pixel (0,0) (VDE=1, FRAME_START=1) and counters become (1,0).
- Pixel data when not active: 0x00 on all channels. Encoders ignore it; the zero value is still required.
- PATTERN sampling: sampled into the latched-pattern register only when (hcnt,vcnt)=(0,0). Changes mid-frame take effect on the next frame. The (0,0) pixel itself uses the newly sampled value.
- Pattern 0, colour bars:
  - Eight bars of BAR_W=H_ACTIVE/8 pixels (integer divide). Pixels beyond 8*BAR_W are black.
  - Bar index comes from a sequential sub-counter reset at hcnt=0, not from a divider.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Pattern 1, grey ramp: R=G=B=hcnt[7:0], wraps every 256 pixels.
- Pattern 2, checkerboard: hcnt[4]^vcnt[4]: 1 gives FFFFFF, 0 gives 000000.
- Pattern 3, solid: SOLID_RGB.
- FRAME_START: high for exactly the cycle in which outputs show (0,0).
- Counter widths: 12 bits each; totals up to 4095 supported.

Test Plan:
- Reset release, pattern 0:
  - First edge with RST_N=1 → VDE=1, FRAME_START=1, RGB=FFFFFF.
  - VDE stays 1 for 640 cycles, then 0 for 160.
  - Second line's VDE rises at cycle 800.
- Line timing: count from the FRAME_START cycle (cycle 0) → HSYNC low on cycles 656..751 and high otherwise. Check 3 consecutive lines, including one in vertical blanking.
- Frame timing:
  - VSYNC low on cycles 490*800 through 492*800-1.
  - VDE never 1 on lines 480..524.
  - Next FRAME_START at cycle 420000.
- Patterns:
  - Pattern 0, line 0: RGB at pixels 79/80/159/160/639 = FFFFFF/FFFF00/FFFF00/00FFFF/000000.
  - Pattern 1, pixel 300: RGB=2C2C2C.
  - Pattern 2: pixel (16,0)=FFFFFF, pixel (16,16)=000000.
- Pattern switch mid-frame: PATTERN 0→3 at line 100 → remainder of the frame stays bars; the next frame is solid FF0000 from its FRAME_START cycle.
- Reset mid-frame: RST_N low for 1 edge at line 200, pixel 300 → next outputs HSYNC=1, VSYNC=1, VDE=0, RGB=0. Then a normal FRAME_START on the first edge after release.
